// File: rtl/duty_cycle_monitor_pkg.sv
// Shared types and helpers for the duty cycle monitor.
// dcm_state_t : measurement FSM states
// duty_bound  : lower/upper duty limit in percent from target and tolerance
package dcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dcm_state_t;

    // Percent limit used to scale the period in the duty compare.
    function automatic int unsigned duty_bound(int unsigned duty_pct,
                                               int unsigned tol_pct,
                                               bit          upper);
        return upper ? (duty_pct + tol_pct) : (duty_pct - tol_pct);
    endfunction

endpackage

// File: rtl/duty_cycle_monitor_if.sv
// Measurement bundle produced by the duty cycle monitor.
// master: the monitor (drives results); slave: any consumer.
// meas_valid : one-cycle pulse, new results valid
// period     : last full period in clk cycles
// high_time  : high portion of last period in clk cycles
// duty_ok    : last measurement within tolerance
// stuck      : monitored signal has stopped toggling (level)
interface duty_cycle_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             duty_ok;
    logic             stuck;

    modport master (
        output meas_valid,
        output period,
        output high_time,
        output duty_ok,
        output stuck
    );

    modport slave (
        input meas_valid,
        input period,
        input high_time,
        input duty_ok,
        input stuck
    );
endinterface

// File: rtl/duty_cycle_monitor_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus registered edge detect.
// clk, rst_n : system clock, async active-low reset
// d          : asynchronous input
// rise, fall : one-cycle pulses on synchronised rising / falling edges
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s;
    logic s_d;

    // meta/s form the synchroniser; s_d is the previous synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= d;
            s    <= meta;
            s_d  <= s;
            rise <= s & ~s_d;
            fall <= ~s & s_d;
        end
    end

endmodule

// File: rtl/duty_cycle_monitor.sv
// Measures period and high time of an asynchronous clock-like signal in clk
// cycles and flags whether its duty cycle lies within DUTY_PCT +/- TOL_PCT.
// clk, rst_n : system clock, async active-low reset
// sig_in     : monitored signal, asynchronous to clk
// mon        : measurement outputs (meas_valid, period, high_time, duty_ok, stuck)
module duty_cycle_monitor
    import dcm_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DUTY_PCT = 40,
    parameter int unsigned TOL_PCT  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    duty_cycle_monitor_if.master mon
);

    // One spare bit over CNT_W+7 so DUTY_PCT+TOL_PCT up to 198 cannot wrap.
    localparam int unsigned XW     = CNT_W + 8;
    localparam int unsigned LO_PCT = duty_bound(DUTY_PCT, TOL_PCT, 1'b0);
    localparam int unsigned HI_PCT = duty_bound(DUTY_PCT, TOL_PCT, 1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rise;
    logic             fall;
    dcm_state_t       state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    logic             meas_valid_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             duty_ok_q;
    logic             stuck_q;

    logic [CNT_W:0]   sum_c;
    logic [XW-1:0]    hi_scaled_c;
    logic [XW-1:0]    lo_lim_c;
    logic [XW-1:0]    hi_lim_c;
    logic             in_spec_c;
    logic             sat_c;

    edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    // Duty compare by cross-multiplication; an overflowing period is never in spec
    always_comb begin
        sum_c       = {1'b0, hi_cnt} + {1'b0, lo_cnt};
        hi_scaled_c = XW'(hi_cnt) * XW'(100);
        lo_lim_c    = XW'(sum_c) * XW'(LO_PCT);
        hi_lim_c    = XW'(sum_c) * XW'(HI_PCT);
        in_spec_c   = !sum_c[CNT_W] && (hi_scaled_c >= lo_lim_c) && (hi_scaled_c <= hi_lim_c);
        sat_c       = (hi_cnt == CNT_MAX) || (lo_cnt == CNT_MAX);
    end

    // FSM, counters and output registers; rise takes priority over saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            duty_ok_q    <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (rise) begin
                state   <= HIGH;
                hi_cnt  <= CNT_W'(1);
                lo_cnt  <= '0;
                stuck_q <= 1'b0;
                if (state == LOW) begin
                    meas_valid_q <= 1'b1;
                    high_time_q  <= hi_cnt;
                    period_q     <= sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
                    duty_ok_q    <= in_spec_c;
                end
            end else if ((state != IDLE) && sat_c) begin
                stuck_q <= 1'b1;
                state   <= IDLE;
            end else begin
                case (state)
                    HIGH: begin
                        // The fall cycle is the first low cycle
                        if (fall) begin
                            state  <= LOW;
                            lo_cnt <= lo_cnt + CNT_W'(1);
                        end else begin
                            hi_cnt <= hi_cnt + CNT_W'(1);
                        end
                    end
                    LOW:     lo_cnt <= lo_cnt + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign mon.meas_valid = meas_valid_q;
    assign mon.period     = period_q;
    assign mon.high_time  = high_time_q;
    assign mon.duty_ok    = duty_ok_q;
    assign mon.stuck      = stuck_q;

endmodule

// File: tb/tb_duty_cycle_monitor.sv
// Directed bench for duty_cycle_monitor: a default 16-bit instance and an 8-bit
// instance share one stimulus; the 8-bit one covers counter saturation.
module tb_duty_cycle_monitor;

    logic clk;
    logic rst_n;
    logic sig_in;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned last_rise_cyc;
    int unsigned last_meas_cyc16;
    int unsigned pulses16;
    int unsigned pulses8;
    int unsigned p16;
    int unsigned p8;

    duty_cycle_monitor_if #(.CNT_W(16)) mon16 ();
    duty_cycle_monitor_if #(.CNT_W(8))  mon8 ();

    duty_cycle_monitor #(.CNT_W(16), .DUTY_PCT(40), .TOL_PCT(5)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .mon    (mon16)
    );

    duty_cycle_monitor #(.CNT_W(8), .DUTY_PCT(40), .TOL_PCT(5)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .mon    (mon8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and timestamp of the latest measurement
    always @(negedge clk) begin
        if (mon16.meas_valid) begin
            pulses16        <= pulses16 + 1;
            last_meas_cyc16 <= cyc;
        end
        if (mon8.meas_valid) pulses8 <= pulses8 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sig_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // n periods of h cycles high then l cycles low, edges on negedge
    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            sig_in        = 1'b1;
            last_rise_cyc = cyc;
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        pulses16 = 0; pulses8 = 0; last_meas_cyc16 = 0; last_rise_cyc = 0;
        rst_n  = 1'b0;
        sig_in = 1'b0;

        // Reset held while sig_in toggles
        repeat (10) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        @(negedge clk);
        chk("rst_pulses",    pulses16, 0);
        chk("rst_period",    mon16.period, 0);
        chk("rst_high_time", mon16.high_time, 0);
        chk("rst_duty_ok",   mon16.duty_ok, 0);
        chk("rst_stuck",     mon16.stuck, 0);
        chk("rst_period8",   mon8.period, 0);

        // Nominal 4/6: 5 rises give 4 measurements
        do_reset();
        p16 = pulses16;
        wave(4, 6, 5);
        settle();
        chk("nom_pulses",    pulses16 - p16, 4);
        chk("nom_period",    mon16.period, 10);
        chk("nom_high_time", mon16.high_time, 4);
        chk("nom_duty_ok",   mon16.duty_ok, 1);
        chk("nom_latency",   last_meas_cyc16 - last_rise_cyc, 4);
        chk("nom_period8",   mon8.period, 10);

        // 60% duty is out of spec
        do_reset();
        p16 = pulses16;
        wave(6, 4, 2);
        settle();
        chk("hi60_pulses",    pulses16 - p16, 1);
        chk("hi60_period",    mon16.period, 10);
        chk("hi60_high_time", mon16.high_time, 6);
        chk("hi60_duty_ok",   mon16.duty_ok, 0);

        // 9/20 = 45%: upper boundary, inclusive
        do_reset();
        wave(9, 11, 2);
        settle();
        chk("b45_period",  mon16.period, 20);
        chk("b45_high",    mon16.high_time, 9);
        chk("b45_duty_ok", mon16.duty_ok, 1);

        // 7/20 = 35%: lower boundary, inclusive
        do_reset();
        wave(7, 13, 2);
        settle();
        chk("b35_duty_ok", mon16.duty_ok, 1);

        // 6/20 = 30%: just below
        do_reset();
        wave(6, 14, 2);
        settle();
        chk("b30_high",    mon16.high_time, 6);
        chk("b30_duty_ok", mon16.duty_ok, 0);

        // Single-cycle high pulse is a legal period
        do_reset();
        wave(1, 9, 2);
        settle();
        chk("gl_period",  mon16.period, 10);
        chk("gl_high",    mon16.high_time, 1);
        chk("gl_duty_ok", mon16.duty_ok, 0);

        // Minimum 1/1 toggling
        do_reset();
        p16 = pulses16;
        wave(1, 1, 5);
        settle();
        chk("min_pulses",  pulses16 - p16, 4);
        chk("min_period",  mon16.period, 2);
        chk("min_high",    mon16.high_time, 1);
        chk("min_duty_ok", mon16.duty_ok, 0);

        // Stuck low on the 8-bit instance
        do_reset();
        p8 = pulses8;
        wave(4, 6, 1);
        repeat (200) @(negedge clk);
        chk("stk_early8", mon8.stuck, 0);
        repeat (100) @(negedge clk);
        chk("stk_set8",    mon8.stuck, 1);
        chk("stk_pulses8", pulses8 - p8, 0);
        chk("stk_clear16", mon16.stuck, 0);

        // Resume: first rise clears stuck without measuring, second rise measures
        p8     = pulses8;
        sig_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("res_stuck8",   mon8.stuck, 0);
        chk("res_first8",   pulses8 - p8, 0);
        sig_in = 1'b0;
        repeat (6) @(negedge clk);
        wave(4, 6, 1);
        settle();
        chk("res_pulses8",  pulses8 - p8, 1);
        chk("res_period8",  mon8.period, 12);
        chk("res_high8",    mon8.high_time, 6);

        // Reset while HIGH: outputs clear, first rise after release is start-only
        do_reset();
        wave(4, 6, 2);
        settle();
        chk("mid_pre_period", mon16.period, 10);
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_period",  mon16.period, 0);
        chk("mid_high",    mon16.high_time, 0);
        chk("mid_duty_ok", mon16.duty_ok, 0);
        chk("mid_valid",   mon16.meas_valid, 0);
        rst_n = 1'b1;
        p16   = pulses16;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_first",  pulses16 - p16, 0);
        wave(4, 6, 1);
        settle();
        chk("mid_next",   pulses16 - p16, 1);
        chk("mid_period2", mon16.period, 12);
        chk("mid_high2",   mon16.high_time, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
